// File: rtl/gain_stage_pkg.sv
// gain_stage_pkg
//   Shared definitions for the multichannel gain stage:
//   - state_e    : frame sequencer states
//   - shift_amt  : right-shift applied to the sample*gain product
//   - saturate   : clamp a wide signed value into a w-bit signed range
//   - overflows  : flag telling whether saturate() had to clamp
package gain_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_e;

  // Width of the generic saturation datapath; any product that fits in
  // 64 bits can be clamped by the helpers below.
  localparam int unsigned SAT_W = 64;

  // A gain word with MULT_W-1 fraction bits and OFFSET headroom bits maps
  // unity onto 2^(MULT_W-1-OFFSET).
  function automatic int shift_amt(input int mult_w, input int offset);
    return mult_w - 1 - offset;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic overflows(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/gain_slew_limiter.sv
// gain_slew_limiter
//   Holds the applied gain and moves it toward a target by at most
//   RAMP_STEP per update strobe (RAMP_STEP = 0: jump straight to target).
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset (gain -> 0)
//     target_i       : signed target gain
//     update_i       : one-cycle strobe, advance the gain toward target_i
//     cur_gain_o     : signed gain currently applied
module gain_slew_limiter #(
  parameter int MULT_W    = 9,
  parameter int RAMP_STEP = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [MULT_W-1:0] target_i,
  input  logic              update_i,
  output logic [MULT_W-1:0] cur_gain_o
);

  // Step at MULT_W+1 bits for the distance compare, at MULT_W bits for the
  // update itself (the result never overshoots the target, so it fits).
  localparam logic signed [MULT_W:0] STEP_W = RAMP_STEP[MULT_W:0];
  localparam logic [MULT_W-1:0]      STEP_N = RAMP_STEP[MULT_W-1:0];

  logic [MULT_W-1:0]      cur_gain_q, cur_gain_d;
  logic signed [MULT_W:0] target_ext;
  logic signed [MULT_W:0] cur_ext;
  logic signed [MULT_W:0] diff;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    target_ext = {target_i[MULT_W-1], target_i};
    cur_ext    = {cur_gain_q[MULT_W-1], cur_gain_q};
    diff       = target_ext - cur_ext;
    cur_gain_d = cur_gain_q;
    if (update_i) begin
      cur_gain_d = target_i;
      if (RAMP_STEP != 0) begin
        if (diff > STEP_W)       cur_gain_d = cur_gain_q + STEP_N;
        else if (diff < -STEP_W) cur_gain_d = cur_gain_q - STEP_N;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all flops sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cur_gain_q <= '0;
    else          cur_gain_q <= cur_gain_d;
  end

  assign cur_gain_o = cur_gain_q;

endmodule

// File: rtl/multichannel_gain_stage.sv
// multichannel_gain_stage
//   Applies one slew-limited signed gain to CHANNELS packed samples per frame
//   through a single shared multiplier, with saturating output.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     data_i         : packed input samples, channel 0 in the LSBs
//     valid_i        : frame valid; accepted when ready_o is also high
//     ready_o        : stage can accept a frame (IDLE or DONE)
//     gain_i         : signed target gain, sampled on accept
//     data_o         : packed output samples, coherent while valid_o is high
//     valid_o        : one-cycle pulse when the whole frame has been written
//     sat_o          : some lane of the current frame saturated
//     cur_gain_o     : gain applied to the last accepted frame
module multichannel_gain_stage
  import gain_stage_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DWIDTH    = 16,
  parameter int MULT_W    = 9,
  parameter int OFFSET    = 1,
  parameter int RAMP_STEP = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [CHANNELS*DWIDTH-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [MULT_W-1:0]          gain_i,
  output logic [CHANNELS*DWIDTH-1:0] data_o,
  output logic                       valid_o,
  output logic                       sat_o,
  output logic [MULT_W-1:0]          cur_gain_o
);

  localparam int SHIFT  = shift_amt(MULT_W, OFFSET);
  localparam int PROD_W = DWIDTH + MULT_W;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [DWIDTH-1:0]         in_q [CHANNELS];
  logic [DWIDTH-1:0]         in_d [CHANNELS];
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic [CH_W-1:0]           prod_ch_q, prod_ch_d;
  logic                      prod_vld_q, prod_vld_d;
  logic [DWIDTH-1:0]         out_q [CHANNELS];
  logic [DWIDTH-1:0]         out_d [CHANNELS];
  logic                      sat_q, sat_d;

  logic                      accept;
  logic [MULT_W-1:0]         cur_gain;
  logic signed [DWIDTH-1:0]  mul_a;
  logic signed [MULT_W-1:0]  mul_b;
  logic signed [PROD_W-1:0]  prod_shifted;
  logic signed [SAT_W-1:0]   wide;
  logic [DWIDTH-1:0]         clipped;

  assign ready_o = (state_q == IDLE) || (state_q == DONE);
  assign valid_o = (state_q == DONE);
  assign accept  = valid_i && ready_o;

  // The new gain is registered on the accept edge, so the MUL cycles of the
  // same frame already multiply by it.
  gain_slew_limiter #(
    .MULT_W    (MULT_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_slew (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .target_i   (gain_i),
    .update_i   (accept),
    .cur_gain_o (cur_gain)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    in_d         = in_q;
    prod_d       = prod_q;
    prod_ch_d    = prod_ch_q;
    prod_vld_d   = 1'b0;
    out_d        = out_q;
    sat_d        = sat_q;

    mul_a        = $signed(in_q[ch_q]);
    mul_b        = $signed(cur_gain);
    prod_shifted = prod_q >>> SHIFT;
    wide         = SAT_W'(prod_shifted);
    clipped      = DWIDTH'(saturate(wide, DWIDTH));

    // Retire the product registered last cycle into its output lane.
    if (prod_vld_q) begin
      out_d[prod_ch_q] = clipped;
      sat_d            = sat_q | overflows(wide, DWIDTH);
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          for (int i = 0; i < CHANNELS; i++) begin
            in_d[i] = data_i[i*DWIDTH +: DWIDTH];
          end
          ch_d    = '0;
          sat_d   = 1'b0;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        prod_d     = PROD_W'(mul_a) * PROD_W'(mul_b);
        prod_ch_d  = ch_q;
        prod_vld_d = 1'b1;
        if (ch_q == LAST_CH) state_d = LAST;
        else                 ch_d    = ch_q + CH_W'(1);
      end
      LAST:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the sample arrays are reset along with the control state so a
  // mid-frame reset leaves data_o at zero rather than at stale contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      prod_q     <= '0;
      prod_ch_q  <= '0;
      prod_vld_q <= 1'b0;
      sat_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        in_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      prod_q     <= prod_d;
      prod_ch_q  <= prod_ch_d;
      prod_vld_q <= prod_vld_d;
      sat_q      <= sat_d;
      in_q       <= in_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      data_o[i*DWIDTH +: DWIDTH] = out_q[i];
    end
  end

  assign sat_o      = sat_q;
  assign cur_gain_o = cur_gain;

endmodule

// File: tb/tb_multichannel_gain_stage.sv
// tb_multichannel_gain_stage
//   Directed bench: dut_a uses the default ramp (RAMP_STEP=8), dut_b jumps
//   straight to the target gain (RAMP_STEP=0). Inputs change on the falling
//   edge, outputs are sampled on the falling edge.
module tb_multichannel_gain_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        valid_a, ready_a, valid_oa, sat_a;
  logic [31:0] data_a, dout_a;
  logic [8:0]  gain_a, cur_a;

  logic        valid_b, ready_b, valid_ob, sat_b;
  logic [31:0] data_b, dout_b;
  logic [8:0]  gain_b, cur_b;

  int checks = 0;
  int errors = 0;

  multichannel_gain_stage #(
    .CHANNELS(2), .DWIDTH(16), .MULT_W(9), .OFFSET(1), .RAMP_STEP(8)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .gain_i(gain_a), .data_o(dout_a), .valid_o(valid_oa),
    .sat_o(sat_a), .cur_gain_o(cur_a)
  );

  multichannel_gain_stage #(
    .CHANNELS(2), .DWIDTH(16), .MULT_W(9), .OFFSET(1), .RAMP_STEP(0)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .gain_i(gain_b), .data_o(dout_b), .valid_o(valid_ob),
    .sat_o(sat_b), .cur_gain_o(cur_b)
  );

  // Drive one frame into dut_a and wait (bounded) for valid_o.
  // lat = number of falling edges after the accept edge, -1 on timeout.
  task automatic run_frame_a(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [8:0] g, output logic [31:0] dout,
                             output logic sat, output logic [8:0] cg,
                             output int lat);
    @(negedge clk);
    data_a = {s1, s0}; gain_a = g; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    lat = 1;
    while (valid_oa !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (valid_oa !== 1'b1) lat = -1;
    dout = dout_a; sat = sat_a; cg = cur_a;
  endtask

  task automatic run_frame_b(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [8:0] g, output logic [31:0] dout,
                             output logic sat, output logic [8:0] cg,
                             output int lat);
    @(negedge clk);
    data_b = {s1, s0}; gain_b = g; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    lat = 1;
    while (valid_ob !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (valid_ob !== 1'b1) lat = -1;
    dout = dout_b; sat = sat_b; cg = cur_b;
  endtask

  task automatic test_reset();
    logic [45:0] got_a, got_b, exp;
    rst_n = 1'b0;
    valid_a = 1'b0; data_a = '0; gain_a = '0;
    valid_b = 1'b0; data_b = '0; gain_b = '0;
    #12;
    // {ready, valid, sat, data, cur_gain}
    exp   = {1'b1, 1'b0, 1'b0, 32'h0, 9'h0, 2'b00};
    got_a = {ready_a, valid_oa, sat_a, dout_a, cur_a, 2'b00};
    got_b = {ready_b, valid_ob, sat_b, dout_b, cur_b, 2'b00};
    checks++;
    if (got_a !== exp) begin
      errors++;
      $display("FAIL reset_a: got %h expected %h", got_a, exp);
    end
    checks++;
    if (got_b !== exp) begin
      errors++;
      $display("FAIL reset_b: got %h expected %h", got_b, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    logic [31:0] dout, exp_d;
    logic        sat;
    logic [8:0]  cg;
    int          lat, e;
    for (int k = 1; k <= 16; k++) begin
      run_frame_a(16'd16000, 16'd16000, 9'd128, dout, sat, cg, lat);
      e     = 1000 * k;
      exp_d = {e[15:0], e[15:0]};
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL ramp_latency frame %0d: got %0d expected 4", k, lat);
      end
      checks++;
      if ({dout, cg, sat} !== {exp_d, 9'(8 * k), 1'b0}) begin
        errors++;
        $display("FAIL ramp_frame %0d: got data %h gain %0d sat %b expected data %h gain %0d sat 0",
                 k, dout, cg, sat, exp_d, 8 * k);
      end
    end
  endtask

  task automatic test_pos_sat();
    logic [31:0] dout;
    logic        sat;
    logic [8:0]  cg;
    int          lat;
    // 20000*255>>>7 = 39843 -> 32767 ; 100*255>>>7 = 199
    run_frame_b(16'd20000, 16'd100, 9'd255, dout, sat, cg, lat);
    checks++;
    if ({dout, sat, cg} !== {16'd199, 16'h7FFF, 1'b1, 9'd255} || lat != 4) begin
      errors++;
      $display("FAIL pos_sat: got data %h sat %b gain %h lat %0d expected data 00c77fff sat 1 gain 0ff lat 4",
               dout, sat, cg, lat);
    end
  endtask

  task automatic test_neg_sat();
    logic [31:0] dout;
    logic        sat;
    logic [8:0]  cg;
    int          lat;
    // gain -256: 20000 -> -40000 -> -32768 ; -50 -> 100
    run_frame_b(16'd20000, 16'hFFCE, 9'h100, dout, sat, cg, lat);
    checks++;
    if ({dout, sat, cg} !== {16'h0064, 16'h8000, 1'b1, 9'h100}) begin
      errors++;
      $display("FAIL neg_sat: got data %h sat %b gain %h expected data 00648000 sat 1 gain 100",
               dout, sat, cg);
    end
    // gain 64: -3 -> -192>>>7 = -2 (floor) ; 4 -> 2
    run_frame_b(16'hFFFD, 16'd4, 9'd64, dout, sat, cg, lat);
    checks++;
    if ({dout, sat, cg} !== {16'h0002, 16'hFFFE, 1'b0, 9'd64}) begin
      errors++;
      $display("FAIL floor_round: got data %h sat %b gain %h expected data 0002fffe sat 0 gain 040",
               dout, sat, cg);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] frames [3];
    logic        exp_ready, exp_valid;
    frames[0] = {16'hFF9C, 16'd100};   // {-100, 100}
    frames[1] = {16'd300,  16'd200};
    frames[2] = {16'd5,    16'hFE70};  // {5, -400}
    gain_a = 9'd128;                   // already reached, output = input
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      exp_ready = (n % 4 == 0) || (n > 12);
      exp_valid = (n == 4) || (n == 8) || (n == 12);
      checks++;
      if (ready_a !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d: got %b expected %b", n, ready_a, exp_ready);
      end
      checks++;
      if (valid_oa !== exp_valid) begin
        errors++;
        $display("FAIL b2b_valid cycle %0d: got %b expected %b", n, valid_oa, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (dout_a !== frames[n/4 - 1]) begin
          errors++;
          $display("FAIL b2b_data cycle %0d: got %h expected %h", n, dout_a, frames[n/4 - 1]);
        end
      end
      valid_a = (n <= 8);
      if (n <= 8) data_a = frames[n/4];
    end
    valid_a = 1'b0;
  endtask

  task automatic test_ignored_input();
    int highs;
    @(negedge clk);
    data_a = {16'hFFB3, 16'd1234}; gain_a = 9'd128; valid_a = 1'b1;
    @(negedge clk);                  // MUL, first lane
    valid_a = 1'b0;
    @(negedge clk);                  // MUL, second lane: not ready
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL ignored_precond_ready: got %b expected 0", ready_a);
    end
    data_a = {16'd7, 16'd7}; valid_a = 1'b1;
    @(negedge clk);                  // LAST
    valid_a = 1'b0;
    @(negedge clk);                  // DONE
    checks++;
    if ({valid_oa, dout_a} !== {1'b1, 16'hFFB3, 16'd1234}) begin
      errors++;
      $display("FAIL ignored_data: got valid %b data %h expected valid 1 data ffb304d2",
               valid_oa, dout_a);
    end
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_oa === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL ignored_no_frame: got %0d valid pulses expected 0", highs);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [31:0] dout;
    logic        sat;
    logic [8:0]  cg;
    int          lat, highs;
    @(negedge clk);
    data_a = {16'd16000, 16'd16000}; gain_a = 9'd128; valid_a = 1'b1;
    @(posedge clk);                  // accept
    @(negedge clk);
    valid_a = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, valid_oa, sat_a, dout_a, cur_a} !== {1'b1, 1'b0, 1'b0, 32'h0, 9'h0}) begin
      errors++;
      $display("FAIL midreset_outputs: got ready %b valid %b sat %b data %h gain %h expected 1 0 0 00000000 000",
               ready_a, valid_oa, sat_a, dout_a, cur_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_oa === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL midreset_no_valid: got %0d valid pulses expected 0", highs);
    end
    run_frame_a(16'd16000, 16'd16000, 9'd128, dout, sat, cg, lat);
    checks++;
    if ({dout, cg, sat} !== {16'd1000, 16'd1000, 9'd8, 1'b0} || lat != 4) begin
      errors++;
      $display("FAIL midreset_restart: got data %h gain %0d sat %b lat %0d expected data 03e803e8 gain 8 sat 0 lat 4",
               dout, cg, sat, lat);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_pos_sat();
    test_neg_sat();
    test_back_to_back();
    test_ignored_input();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multichannel_gain_stage.md
Name: multichannel_gain_stage

Overview:
- Registered, multi-channel successor to the combinational fractional-gain multiplier.
- Applies one signed gain word to CHANNELS parallel audio samples per frame, using a single time-multiplexed multiplier.
- Output is saturated, not wrapped. Gain changes are slew-limited per frame to suppress zipper noise.
- Sits between the effect mixers and the codec output path; it is the new shared volume/attenuation stage.

Parameters:
- CHANNELS, 2: number of parallel channels per frame (>=1).
- DWIDTH, 16: sample width, signed two's complement.
- MULT_W, 9: gain word width, signed.
- OFFSET, 1: headroom bits. Product is arithmetic-shifted right by MULT_W-1-OFFSET; maximum gain is about 2^OFFSET. Must satisfy 0 <= OFFSET < MULT_W-1.
- RAMP_STEP, 8: maximum gain change per accepted frame. 0 means the gain jumps immediately to gain_i.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- data_i  in  CHANNELS*DWIDTH  packed input samples; channel 0 in the LSBs
- valid_i  in  1  input frame valid
- ready_o  out  1  stage can accept a frame
- gain_i  in  MULT_W  signed target gain, sampled on each accepted frame
- data_o  out  CHANNELS*DWIDTH  packed output samples, held until the next frame completes
- valid_o  out  1  one-cycle pulse: data_o updated
- sat_o  out  1  at least one channel of the current data_o saturated
- cur_gain_o  out  MULT_W  gain actually applied to the last accepted frame

Behaviour:
- Reset values: ready_o=1, valid_o=0, sat_o=0, data_o=0, cur_gain_o=0. The internal channel counter and FSM return to IDLE.
- Because the gain resets to 0, the output fades in after reset.
- Reset asserted mid-frame aborts the frame. No valid_o is produced for it.
- Handshake: a frame is accepted when valid_i && ready_o at a rising edge. valid_i while ready_o=0 is ignored (no buffering; upstream must hold or drop).
- FSM states:
  - IDLE: ready_o=1. On accept, latch data_i, update gain, set ch=0, go to MUL.
  - MUL: one channel per cycle. Register the product data[ch]*cur_gain (DWIDTH+MULT_W bits, signed). ch increments. After ch=CHANNELS-1, go to LAST.
  - LAST: the final product is shifted and saturated into data_o. Go to DONE.
  - DONE: valid_o=1, ready_o=1. An accept in this cycle goes directly to MUL; otherwise go to IDLE.
- Each product is shifted/saturated and written into its data_o lane one cycle after it is registered. data_o lanes are therefore updated progressively. Only the valid_o cycle guarantees a coherent frame.
- Latency: valid_o is high exactly CHANNELS+2 cycles after the accept edge.
- Throughput: one frame per CHANNELS+2 cycles (back-to-back via DONE).
- Gain slew, computed at accept from the previous cur_gain:
  - diff = gain_i - cur_gain.
  - If |diff| <= RAMP_STEP, or RAMP_STEP = 0: cur_gain = gain_i.
  - Otherwise cur_gain moves by ±RAMP_STEP toward gain_i.
  - Computed at MULT_W+1 bits, so no overflow at the extremes.
  - The new cur_gain applies to this frame.
- Arithmetic:
  - result = product >>> (MULT_W-1-OFFSET), floor rounding.
  - Saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - sat_o is recomputed per frame: OR of per-lane overflow flags, cleared on accept, valid at valid_o.
- Negative gains are legal and invert polarity. gain = -2^(MULT_W-1) is permitted and saturates correctly.

Decomposition:
- Package gain_stage_pkg holds:
  - localparam function for the shift amount, shift_amt(MULT_W, OFFSET).
  - Generic saturate function: width-parameterised via a let/function taking the wide value.
  - FSM state enum: IDLE, MUL, LAST, DONE.
- One sub-module, gain_slew_limiter:
  - Holds cur_gain.
  - Inputs: target, update strobe.
  - Parameters: MULT_W, RAMP_STEP.
  - Reusable by the mixer's crossfade control.

Test Plan (CHANNELS=2, DWIDTH=16, MULT_W=9, OFFSET=1, unity gain = 128):
- Ramp from reset: gain_i=128, frames of {16000,16000} -> first output {1000,1000} (cur_gain 8). cur_gain_o reaches 128 on frame 16; frame 16 outputs {16000,16000}.
- Positive saturation: RAMP_STEP=0, gain_i=255, {20000,100} -> {32767,199}, sat_o=1.
- Negative saturation and inversion: RAMP_STEP=0, gain_i=-256, {20000,-50} -> {-32768,100}, sat_o=1. Next frame gain_i=64, {-3,4} -> {-2,2}, sat_o=0 (floor rounding).
- Timing/back-to-back: valid_i held high for 3 frames -> valid_o pulses 4 cycles after each accept, accepts spaced 4 cycles apart. ready_o is low exactly in MUL/LAST.
- Reset mid-frame: assert rst_n_i one cycle after accept -> no valid_o, outputs return to 0, ready_o=1 immediately. The next frame processes normally with cur_gain restarting from 0.
- Ignored input: pulse valid_i while ready_o=0 with {7,7} -> not captured; the output equals the previously accepted frame's result.
